// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation zone controller: controller states
// and the tank-level encoding seen on the lvl input.
package irrig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOWLVL = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] LVL_EMPTY = 2'b00;
    localparam logic [1:0] LVL_LOW   = 2'b01;
    localparam logic [1:0] LVL_MID   = 2'b10;
    localparam logic [1:0] LVL_FULL  = 2'b11;

endpackage

// File: rtl/irrig_zone_ctrl_if.sv
// Request/valve bundle between a zone requester (master) and the controller
// (slave). ovr_off only exists when IRRIG_OVERRIDE_EN is defined.
interface irrig_zone_ctrl_if #(
    parameter int NZ = 4,
    parameter int TW = 8
);
    logic [NZ-1:0] req;
    logic [TW-1:0] dur;
    logic [1:0]    lvl;
    logic [NZ-1:0] valve;
    logic [NZ-1:0] done;
    logic          err;
    logic          busy;
`ifdef IRRIG_OVERRIDE_EN
    logic          ovr_off;

    modport master (output req, dur, lvl, ovr_off, input valve, done, err, busy);
    modport slave  (input req, dur, lvl, ovr_off, output valve, done, err, busy);
`else
    modport master (output req, dur, lvl, input valve, done, err, busy);
    modport slave  (input req, dur, lvl, output valve, done, err, busy);
`endif
endinterface

// File: rtl/irrig_zone_timer.sv
// One zone's watering timer: load on grant, count down while open, and flag
// a natural expiry. A clear closes the zone without flagging expiry.
module irrig_zone_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clr,
    input  logic [TW-1:0] dur,
    output logic          open,
    output logic          expire,
    output logic          open_d
);
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_d;
    logic          exp_d;

    // Next counter value; a zero duration still waters for one cycle.
    always_comb begin
        cnt_d  = cnt;
        open_d = open;
        exp_d  = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            open_d = 1'b0;
        end else if (load) begin
            cnt_d  = (dur == '0) ? TW'(1) : dur;
            open_d = 1'b1;
        end else if (cnt != '0) begin
            cnt_d = cnt - TW'(1);
            if (cnt == TW'(1)) begin
                open_d = 1'b0;
                exp_d  = 1'b1;
            end
        end
    end

    // Counter, valve and expiry-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            open   <= 1'b0;
            expire <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            open   <= open_d;
            expire <= exp_d;
        end
    end
endmodule

// File: rtl/irrig_zone_ctrl.sv
// Irrigation zone controller: round-robin valve grants limited by tank level,
// one timer per zone, fault shutdown on an empty tank.
// Optional feature: define IRRIG_OVERRIDE_EN to add bus.ovr_off, a manual
// shut-off that closes all valves while keeping pending requests.
module irrig_zone_ctrl
    import irrig_pkg::*;
#(
    parameter int NZ     = 4,
    parameter int TW     = 8,
    parameter int MAX_ON = 2
) (
    input  logic             clk,
    input  logic             reset,
    irrig_zone_ctrl_if.slave bus
);
    localparam int PW = (NZ > 1) ? $clog2(NZ) : 1;

    state_t        state, nstate;
    logic [NZ-1:0] pending, pending_d;
    logic [NZ-1:0] gnt, open, open_d, done_w;
    logic [PW-1:0] rr_ptr, rr_d, idx;
    logic          clr, busy_now;
    int            limit, open_cnt;

    // Next state from tank level and current activity; empty tank wins.
    always_comb begin
        busy_now = (|open) | (|pending);
        nstate   = state;
        if (bus.lvl == LVL_EMPTY) begin
            nstate = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE:   if (bus.lvl == LVL_LOW) nstate = ST_LOWLVL;
                           else if (|pending)      nstate = ST_RUN;
                ST_RUN:    if (bus.lvl == LVL_LOW) nstate = ST_LOWLVL;
                           else if (!busy_now)     nstate = ST_IDLE;
                ST_LOWLVL,
                ST_FAULT:  if (bus.lvl >= LVL_MID) nstate = busy_now ? ST_RUN : ST_IDLE;
                default:   nstate = ST_FAULT;
            endcase
        end
    end

    // Grant limit and timer clear follow the state being entered, so a level
    // change takes effect on the same edge.
    always_comb begin
        case (nstate)
            ST_IDLE, ST_RUN: limit = MAX_ON;
            ST_LOWLVL:       limit = 1;
            default:         limit = 0;
        endcase
        clr = (nstate == ST_FAULT);
`ifdef IRRIG_OVERRIDE_EN
        if (bus.ovr_off) begin
            limit = 0;
            clr   = 1'b1;
        end
`endif
    end

    // Single round-robin grant to a pending, currently closed zone.
    always_comb begin
        gnt      = '0;
        rr_d     = rr_ptr;
        idx      = '0;
        open_cnt = $countones(open);
        if (open_cnt < limit) begin
            for (int k = 0; k < NZ; k++) begin
                idx = PW'((int'(rr_ptr) + k) % NZ);
                if (gnt == '0 && pending[idx] && !open[idx]) begin
                    gnt[idx] = 1'b1;
                    rr_d     = PW'((int'(idx) + 1) % NZ);
                end
            end
        end
        pending_d = (pending & ~gnt) | bus.req;
    end

    // Controller state, pointer, pending requests and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            pending  <= '0;
            bus.err  <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state    <= nstate;
            rr_ptr   <= rr_d;
            pending  <= pending_d;
            bus.err  <= (nstate == ST_FAULT);
            bus.busy <= (|open_d) | (|pending_d);
        end
    end

    for (genvar i = 0; i < NZ; i++) begin : g_zone
        irrig_zone_timer #(.TW(TW)) u_tmr (
            .clk    (clk),
            .reset  (reset),
            .load   (gnt[i]),
            .clr    (clr),
            .dur    (bus.dur),
            .open   (open[i]),
            .expire (done_w[i]),
            .open_d (open_d[i])
        );
    end

    assign bus.valve = open;
    assign bus.done  = done_w;
endmodule
